// File: rtl/temp_accum_ctrl.sv
// temp_accum_ctrl: read-modify-write accumulation controller for a small
// temp buffer. Sums NUM_PASSES partial-sum passes element-wise across DEPTH
// entries and streams the finished tile out on a valid/ready interface.
module temp_accum_ctrl #(
  parameter int DATA_W     = 36,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2,
  parameter int NUM_PASSES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [DATA_W-1:0] psum_data,
  output logic              temp_write,
  output logic [ADDR_W-1:0] temp_address,
  output logic [DATA_W-1:0] temp_in,
  input  logic [DATA_W-1:0] temp_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic              done
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD,
    S_ACC,
    S_OUT
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [ADDR_W-1:0]   addr_d;
  logic [PASS_W-1:0]   pass_cnt;
  logic [PASS_W-1:0]   pass_d;
  logic [DATA_W-1:0]   result_d;
  logic                done_d;
  logic                last_pass;
  logic                last_addr;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W-1:0]   sum;

  // Modular DATA_W-bit add: the carry out is deliberately discarded.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign last_pass = (pass_cnt == LAST_PASS);
  assign last_addr = (addr_cnt == LAST_ADDR);

  // Next-state, counter updates and output decode from the registered state.
  always_comb begin
    state_d      = state;
    addr_d       = addr_cnt;
    pass_d       = pass_cnt;
    result_d     = result_data;
    done_d       = 1'b0;
    busy         = (state != S_IDLE);
    psum_ready   = 1'b0;
    temp_write   = 1'b0;
    temp_in      = '0;
    result_valid = 1'b0;
    temp_address = addr_cnt;
    // Pass 0 only reaches ACC in the single-pass build; the buffer holds
    // stale data then, so the addend must be forced to zero.
    addend       = (pass_cnt == '0) ? '0 : temp_out;
    sum          = wrap_add(addend, psum_data);

    case (state)
      S_IDLE: begin
        if (start) state_d = (NUM_PASSES > 1) ? S_WR0 : S_RD;
      end
      S_WR0: begin
        psum_ready = 1'b1;
        temp_in    = psum_data;
        temp_write = psum_valid;
        if (psum_valid) begin
          addr_d = addr_cnt + ADDR_W'(1);
          if (last_addr) begin
            pass_d  = PASS_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        psum_ready = 1'b1;
        if (!last_pass) begin
          temp_in    = sum;
          temp_write = psum_valid;
        end
        if (psum_valid) begin
          if (last_pass) begin
            result_d = sum;
            state_d  = S_OUT;
          end else begin
            addr_d  = addr_cnt + ADDR_W'(1);
            if (last_addr) pass_d = pass_cnt + PASS_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_OUT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if (last_addr) begin
            addr_d  = '0;
            pass_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_cnt + ADDR_W'(1);
            state_d = S_RD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, result register and done pulse; reset aborts any tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_cnt    <= '0;
      pass_cnt    <= '0;
      result_data <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      addr_cnt    <= addr_d;
      pass_cnt    <= pass_d;
      result_data <= result_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_temp_accum_ctrl.sv
// Bench for temp_accum_ctrl: a 3-pass instance with a behavioural temp
// buffer and a 1-pass instance fed stale buffer data.
module tb_temp_accum_ctrl;
  localparam int DW = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, psum_valid, result_ready, sel;
  logic [DW-1:0] psum_data;

  logic          busy0, pr0, tw0, rv0, done0, st0, pv0;
  logic [1:0]    ta0;
  logic [DW-1:0] ti0, tout0, rd0;
  logic          busy1, pr1, tw1, rv1, done1, st1, pv1;
  logic [1:0]    ta1;
  logic [DW-1:0] ti1, tout1, rd1;

  assign st0 = start & ~sel;
  assign pv0 = psum_valid & ~sel;
  assign st1 = start & sel;
  assign pv1 = psum_valid & sel;

  temp_accum_ctrl #(.DATA_W(DW), .DEPTH(4), .ADDR_W(2), .NUM_PASSES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .busy(busy0),
    .psum_valid(pv0), .psum_ready(pr0), .psum_data(psum_data),
    .temp_write(tw0), .temp_address(ta0), .temp_in(ti0), .temp_out(tout0),
    .result_valid(rv0), .result_ready(result_ready), .result_data(rd0), .done(done0));

  temp_accum_ctrl #(.DATA_W(DW), .DEPTH(4), .ADDR_W(2), .NUM_PASSES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .busy(busy1),
    .psum_valid(pv1), .psum_ready(pr1), .psum_data(psum_data),
    .temp_write(tw1), .temp_address(ta1), .temp_in(ti1), .temp_out(tout1),
    .result_valid(rv1), .result_ready(result_ready), .result_data(rd1), .done(done1));

  // Temp buffer: synchronous write, registered read of the presented address.
  logic [DW-1:0] mem0 [0:3];
  always @(posedge clk) begin
    if (tw0) mem0[ta0] <= ti0;
    tout0 <= mem0[ta0];
  end
  // The single-pass instance sees garbage read data that must never be added.
  assign tout1 = 36'hA_5A5A_5A5A;

  logic          o_busy, o_pr, o_tw, o_rv, o_done;
  logic [1:0]    o_ta;
  logic [DW-1:0] o_rd;
  assign o_busy = sel ? busy1 : busy0;
  assign o_pr   = sel ? pr1   : pr0;
  assign o_tw   = sel ? tw1   : tw0;
  assign o_rv   = sel ? rv1   : rv0;
  assign o_done = sel ? done1 : done0;
  assign o_ta   = sel ? ta1   : ta0;
  assign o_rd   = sel ? rd1   : rd0;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] pdata [0:2][0:3];
  logic [DW-1:0] res   [0:3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    logic [63:0] r64;
    for (int p = 0; p < 3; p++)
      for (int e = 0; e < 4; e++) begin
        r64 = {$urandom(), $urandom()};
        pdata[p][e] = r64[DW-1:0];
      end
  endtask

  task automatic fill_basic();
    for (int e = 0; e < 4; e++) begin
      pdata[0][e] = DW'(e + 1);
      pdata[1][e] = DW'(10 * (e + 1));
      pdata[2][e] = DW'(100 * (e + 1));
    end
  endtask

  // mode 0: no gaps; 1: random gaps, backpressure and start spam;
  // 2: 5-cycle result stall plus a 3-cycle psum gap in ACC.
  task automatic run_tile(input int np, input int mode, input bit abort);
    int p = 0, e = 0, cyc = 0, nres = 0, writes = 0;
    int w0 = 0, wfirst = 0, wlast = 0, rstall = 0, gap = 0;
    bit dseen = 0, clash = 0;
    logic [DW-1:0] held = '0, exp;
    logic [1:0] gap_addr = '0;
    logic [63:0] r64;
    @(negedge clk);
    start = 1'b1; psum_valid = 1'b0; result_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", 64'(o_busy), 64'(1));
    while (nres < 4 && cyc < 2000) begin
      if (abort && p == 1 && e == 2) break;
      psum_valid = (p < np) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (mode == 2 && p == 1 && e == 1 && gap < 3) psum_valid = 1'b0;
      r64 = {$urandom(), $urandom()};
      psum_data = (p < np) ? pdata[p][e] : r64[DW-1:0];
      result_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : !(mode == 2 && rstall < 5);
      start = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      #1;
      if (o_done) dseen = 1'b1;
      if (o_tw && o_rv) clash = 1'b1;
      if (o_tw) begin
        writes++;
        if (p == 0) begin
          if (w0 == 0) wfirst = cyc;
          wlast = cyc;
          w0++;
        end
      end
      if (mode == 2 && o_rv && !result_ready) begin
        if (rstall == 0) held = o_rd;
        else chk("stall_data_stable", 64'(o_rd), 64'(held));
        chk("stall_psum_ready", 64'(o_pr), 64'(0));
        rstall++;
      end
      if (mode == 2 && p == 1 && e == 1 && !psum_valid && o_pr) begin
        if (gap == 0) gap_addr = o_ta;
        else chk("gap_addr_held", 64'(o_ta), 64'(gap_addr));
        chk("gap_no_write", 64'(o_tw), 64'(0));
        gap++;
      end
      if (psum_valid && o_pr) begin
        e++;
        if (e == 4) begin e = 0; p++; end
      end
      if (o_rv && result_ready) begin
        if (mode == 2 && nres == 0) chk("stall_data_at_accept", 64'(o_rd), 64'(held));
        res[nres] = o_rd;
        nres++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; psum_valid = 1'b0; result_ready = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_ctrl_zero", 64'({o_busy, o_pr, o_tw, o_rv, o_done}), 64'(0));
      chk("abort_addr_zero", 64'(o_ta), 64'(0));
      chk("abort_tin_zero", 64'(ti0), 64'(0));
      chk("abort_rdata_zero", 64'(o_rd), 64'(0));
      chk("abort_no_done", 64'(dseen), 64'(0));
      return;
    end
    chk("tile_in_budget", 64'(cyc < 2000), 64'(1));
    chk("done_pulse", 64'(o_done), 64'(1));
    chk("busy_low_at_done", 64'(o_busy), 64'(0));
    chk("no_early_done", 64'(dseen), 64'(0));
    chk("write_result_excl", 64'(clash), 64'(0));
    chk("write_count", 64'(writes), 64'(4 * (np - 1)));
    for (int i = 0; i < 4; i++) begin
      exp = '0;
      for (int q = 0; q < np; q++) exp = exp + pdata[q][i];
      chk("result_vs_model", 64'(res[i]), 64'(exp));
    end
    if (mode == 0 && np > 1) begin
      chk("pass0_writes", 64'(w0), 64'(4));
      chk("pass0_consecutive", 64'(wlast - wfirst), 64'(3));
    end
    if (mode == 2) begin
      chk("stall_length", 64'(rstall), 64'(5));
      chk("gap_length", 64'(gap), 64'(3));
    end
    @(negedge clk);
    #1;
    chk("done_single_cycle", 64'(o_done), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst_n = 1'b0; start = 1'b0; psum_valid = 1'b0;
    result_ready = 1'b0; psum_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl0", 64'({busy0, pr0, tw0, rv0, done0}), 64'(0));
    chk("reset_addr_tin0", 64'({ta0, ti0}), 64'(0));
    chk("reset_rdata0", 64'(rd0), 64'(0));
    chk("reset_ctrl1", 64'({busy1, pr1, tw1, rv1, done1}), 64'(0));
    chk("reset_rdata1", 64'(rd1), 64'(0));
    rst_n = 1'b1;

    // Basic accumulation
    fill_basic();
    run_tile(3, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("basic_result", 64'(res[i]), 64'(111 * (i + 1)));

    // Wrap-around on element 0
    fill_random();
    pdata[0][0] = 36'hF_FFFF_FFFF;
    pdata[1][0] = 36'h0_0000_0001;
    pdata[2][0] = 36'h0_0000_0000;
    run_tile(3, 1, 1'b0);
    chk("wrap_result", 64'(res[0]), 64'(0));

    // Backpressure and psum gap
    fill_random();
    run_tile(3, 2, 1'b0);

    // Reset mid-tile, then a clean rerun
    fill_basic();
    run_tile(3, 0, 1'b1);
    run_tile(3, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("post_reset_result", 64'(res[i]), 64'(111 * (i + 1)));

    // Randomized tiles with start pulses while busy
    repeat (4) begin
      fill_random();
      run_tile(3, 1, 1'b0);
    end

    // Single-pass instance
    sel = 1'b1;
    for (int e = 0; e < 4; e++) pdata[0][e] = DW'(e + 5);
    run_tile(1, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("single_result", 64'(res[i]), 64'(i + 5));
    repeat (2) begin
      fill_random();
      run_tile(1, 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
